pi_bus_initiator: RTL and testbench
===================================

Name: pi_bus_initiator

Overview:
- Initiator end of the Pi bus handshake (pi_rw_b / pi_addr / pi_wr_data / pi_pending / pi_done / pi_rd_data).
- Replaces the wide Pi GPIO parallel port with a 4-wire SPI slave. Decodes SPI command frames and issues one bus transaction per command toward the timing/bus arbiter in the top level.
- Captures read data and returns it to the host on the next SPI frame.

Parameters:
- SYNC_STAGES, 2, flip-flop stages synchronizing spi_cs_b/spi_sclk/spi_mosi into clk16 (min 2).
- TIMEOUT_CYCLES, 4096, clk16 cycles allowed in REQ before abort (used only with the optional feature).

Ports:
- clk16  input  1  16 MHz master clock; all logic on rising edge.
- reset_b  input  1  asynchronous, active-low reset.
- spi_cs_b  input  1  SPI chip select, active-low; frame delimiter.
- spi_sclk  input  1  SPI clock, mode 0; max clk16/8.
- spi_mosi  input  1  SPI data in, MSB first.
- spi_miso  output  1  SPI data out, MSB first.
- busy  output  1  1 = command accepted and transaction not yet finished.
- err  output  1  OR of sticky overrun/timeout flags.
- pi_rw_b  output  1  1 = read, 0 = write.
- pi_addr  output  17  transaction address.
- pi_wr_data  output  8  write data.
- pi_rd_data  input  8  read data; valid while pi_done = 1.
- pi_pending  output  1  request to arbiter.
- pi_done  input  1  arbiter completion.

Behaviour:
- Reset values: spi_miso 0, busy 0, err 0, pi_rw_b 1, pi_addr 0, pi_wr_data 0, pi_pending 0. Internal: addr_reg 0, rd_reg 0, flags 0, FSM IDLE.
- SPI inputs pass through SYNC_STAGES flops; edges are detected in the clk16 domain.
- MOSI is sampled on synchronized SCLK rise. MISO shift register updates on SCLK fall.
- spi_cs_b high clears the bit and byte counters. A partial byte is discarded.
- Byte 0 (command) fields:
  - [7:6] op: 00 WRITE, 01 READ, 10 WRITE_NEXT, 11 READ_NEXT.
  - [5] clear sticky flags, applied when byte 0 completes.
  - [0] A16.
- Frame layout:
  - WRITE: cmd, A15:8, A7:0, data. Executes on completion of byte 3.
  - READ: cmd, A15:8, A7:0. Executes on completion of byte 2.
  - WRITE_NEXT: cmd, data. Uses addr_reg.
  - READ_NEXT: cmd only. Uses addr_reg.
- For WRITE and READ, A16 from byte 0 and the two address bytes load addr_reg.
- Bytes beyond the execute point are ignored. A frame ending before its execute point issues no transaction.
- MISO bytes per frame:
  - Byte 0: rd_reg.
  - Every later byte: {busy, overrun, timeout, 5'b0}. Sampled at that byte's start.
- FSM:
  - IDLE: on execute, load pi_rw_b, pi_addr = addr_reg, pi_wr_data; go to REQ. pi_pending = 1 on the cycle after the execute cycle. busy = 1 from the execute cycle.
  - REQ: hold pi_pending and all outputs stable. When pi_done = 1: if read, rd_reg <= pi_rd_data; pi_pending <= 0; go to ACK.
  - ACK: wait for pi_done = 0. Then addr_reg <= addr_reg + 1, wrapping 17'h1FFFF to 0. busy <= 0. Go to IDLE.
- Four-phase handshake: pending is never reasserted while pi_done = 1.
- Overrun: an execute while FSM is not IDLE drops the command and sets overrun. The in-flight transaction is unaffected.
- A flag clear and a flag set in the same cycle: the set wins.
- err = overrun | timeout. It is combinational from the registered flags.
- reset_b low mid-transaction: pi_pending drops immediately (asynchronous) and all state returns to reset values.

Optional Feature:
- Macro: PI_BUS_INITIATOR_TIMEOUT_EN.
- Defined:
  - A counter runs in REQ.
  - On reaching TIMEOUT_CYCLES with no pi_done, drop pi_pending, set timeout, skip the address increment and go to ACK.
  - rd_reg is unchanged.
- Undefined: no counter; REQ waits indefinitely; the timeout flag is tied to 0.

Test Plan:
- WRITE frame 00,E8,0F,03 -> one pi_pending pulse with pi_rw_b = 0, pi_addr 17'h0E80F, pi_wr_data 03. After pi_done rises then falls: busy 0, addr_reg 17'h0E810.
- READ frame 41,23,45; arbiter returns pi_rd_data A5 -> pi_addr 17'h12345 with pi_rw_b = 1. Next frame 00 -> MISO byte 0 = A5, addr_reg 17'h12346.
- READ_NEXT ×3 from addr_reg 17'h1FFFE -> pi_addr sequence 1FFFE, 1FFFF, 00000.
- Hold pi_done = 0 and send a second WRITE_NEXT during REQ -> second command dropped. Status byte = 1100_0000, err = 1. Command 20 clears overrun once idle.
- cs_b deasserted after 2 bytes of a WRITE -> no pi_pending. A stuck pi_done = 1 at IDLE delays the next pending until pi_done = 0.
- With PI_BUS_INITIATOR_TIMEOUT_EN and TIMEOUT_CYCLES 16, pi_done held 0 -> pi_pending falls after 16 cycles, timeout = 1, addr_reg unchanged.

Source files
------------

// File: rtl/pi_bus_initiator.sv
// pi_bus_initiator: SPI-slave front end that issues four-phase Pi bus transactions.
// Optional REQ timeout is built when PI_BUS_INITIATOR_TIMEOUT_EN is defined.
module pi_bus_initiator #(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic        clk16,
   input  logic        reset_b,
   input  logic        spi_cs_b,
   input  logic        spi_sclk,
   input  logic        spi_mosi,
   output logic        spi_miso,
   output logic        busy,
   output logic        err,
   output logic        pi_rw_b,
   output logic [16:0] pi_addr,
   output logic [7:0]  pi_wr_data,
   input  logic [7:0]  pi_rd_data,
   output logic        pi_pending,
   input  logic        pi_done
);
   localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, ACK = 2'd2;
   logic [SYNC_STAGES-1:0] r_cs_sync, r_sclk_sync, r_mosi_sync;
   logic                   r_sclk_d;
   logic [2:0]             r_bit_cnt, r_byte_cnt;
   logic [6:0]             r_shift;
   logic [1:0]             r_op, r_state;
   logic                   r_a16, r_overrun;
   logic [7:0]             r_addr_hi, r_addr_lo, r_rd_reg, r_miso_sr;
   logic [16:0]            r_addr_reg;
   logic                   w_cs, w_sclk, w_rise, w_fall, w_byte_done, w_exec, w_clr;
   logic                   w_timeout, w_to_hit, w_abort;
   logic [7:0]             w_byte;
   logic [1:0]             w_op;
   logic [16:0]            w_exec_addr;

   assign w_cs        = r_cs_sync[SYNC_STAGES-1];
   assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
   assign w_rise      = ~w_cs & w_sclk & ~r_sclk_d;
   assign w_fall      = ~w_cs & ~w_sclk & r_sclk_d;
   assign w_byte      = {r_shift, r_mosi_sync[SYNC_STAGES-1]};
   assign w_byte_done = w_rise & (r_bit_cnt == 3'd7);
   assign w_op        = (r_byte_cnt == 3'd0) ? w_byte[7:6] : r_op;
   assign w_clr       = w_byte_done & (r_byte_cnt == 3'd0) & w_byte[5];
   // Execute byte index is 3 - op: WRITE 3, READ 2, WRITE_NEXT 1, READ_NEXT 0.
   assign w_exec      = w_byte_done & (r_byte_cnt == {1'b0, ~w_op});
   assign w_exec_addr = w_op[1] ? r_addr_reg : {r_a16, r_addr_hi, w_op[0] ? w_byte : r_addr_lo};
   assign spi_miso    = r_miso_sr[7];
   assign err         = r_overrun | w_timeout;

   always_ff @(posedge clk16 or negedge reset_b)
      if (!reset_b) begin
         r_cs_sync   <= '1;
         r_sclk_sync <= '0;
         r_mosi_sync <= '0;
         r_sclk_d    <= 1'b0;
      end else begin
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_b};
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         r_sclk_d    <= w_sclk;
      end

   always_ff @(posedge clk16 or negedge reset_b)
      if (!reset_b) begin
         r_bit_cnt  <= '0;
         r_byte_cnt <= '0;
         r_shift    <= '0;
         r_op       <= '0;
         r_a16      <= 1'b0;
         r_addr_hi  <= '0;
         r_addr_lo  <= '0;
         r_miso_sr  <= '0;
      end else if (w_cs) begin
         r_bit_cnt  <= '0;
         r_byte_cnt <= '0;
         r_miso_sr  <= r_rd_reg;
      end else begin
         if (w_rise) begin
            r_shift   <= w_byte[6:0];
            r_bit_cnt <= r_bit_cnt + 1'b1;
         end
         if (w_byte_done) begin
            if (r_byte_cnt != 3'd7) r_byte_cnt <= r_byte_cnt + 1'b1;
            if (r_byte_cnt == 3'd0) begin
               r_op  <= w_byte[7:6];
               r_a16 <= w_byte[0];
            end
            if (r_byte_cnt == 3'd1) r_addr_hi <= w_byte;
            if (r_byte_cnt == 3'd2) r_addr_lo <= w_byte;
         end
         // A fall with the bit counter at zero starts a new byte after byte 0.
         if (w_fall) r_miso_sr <= (r_bit_cnt == 3'd0) ? {busy, r_overrun, w_timeout, 5'b0} : {r_miso_sr[6:0], 1'b0};
      end

   always_ff @(posedge clk16 or negedge reset_b)
      if (!reset_b) begin
         r_state    <= IDLE;
         busy       <= 1'b0;
         pi_pending <= 1'b0;
         pi_rw_b    <= 1'b1;
         pi_addr    <= '0;
         pi_wr_data <= '0;
         r_addr_reg <= '0;
         r_rd_reg   <= '0;
         r_overrun  <= 1'b0;
      end else begin
         r_overrun <= (w_exec & (r_state != IDLE)) | (r_overrun & ~w_clr);
         case (r_state)
            IDLE: if (w_exec) begin
               r_state    <= REQ;
               busy       <= 1'b1;
               pi_pending <= ~pi_done;
               pi_rw_b    <= w_op[0];
               pi_addr    <= w_exec_addr;
               pi_wr_data <= w_byte;
               if (!w_op[1]) r_addr_reg <= w_exec_addr;
            end
            // Pending waits for a stale pi_done to clear before asserting.
            REQ: if (pi_pending & pi_done) begin
               if (pi_rw_b) r_rd_reg <= pi_rd_data;
               pi_pending <= 1'b0;
               r_state    <= ACK;
            end else if (w_to_hit) begin
               pi_pending <= 1'b0;
               r_state    <= ACK;
            end else if (!pi_pending) pi_pending <= ~pi_done;
            ACK: if (!pi_done) begin
               if (!w_abort) r_addr_reg <= r_addr_reg + 17'd1;
               busy    <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end

`ifdef PI_BUS_INITIATOR_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] r_to_cnt;
   logic          r_timeout, r_abort;
   assign w_to_hit  = (r_state == REQ) & (r_to_cnt == TO_LAST) & ~(pi_pending & pi_done);
   assign w_timeout = r_timeout;
   assign w_abort   = r_abort;

   always_ff @(posedge clk16 or negedge reset_b)
      if (!reset_b) begin
         r_to_cnt  <= '0;
         r_timeout <= 1'b0;
         r_abort   <= 1'b0;
      end else begin
         r_to_cnt  <= (r_state == REQ) ? r_to_cnt + 1'b1 : '0;
         r_timeout <= w_to_hit | (r_timeout & ~w_clr);
         r_abort   <= w_to_hit | (r_abort & (r_state != IDLE));
      end
`else
   logic w_unused_to;
   assign w_to_hit    = 1'b0;
   assign w_timeout   = 1'b0;
   assign w_abort     = 1'b0;
   assign w_unused_to = (TIMEOUT_CYCLES > 0);
`endif
endmodule

// File: tb/tb_pi_bus_initiator.sv
// tb_pi_bus_initiator: SPI-driven stimulus against a frame-level reference model of pi_bus_initiator.
module tb_pi_bus_initiator;
`ifdef PI_BUS_INITIATOR_TIMEOUT_EN
   localparam int TO = 16;
`else
   localparam int TO = 4096;
`endif
   localparam int H = 6;
   typedef struct packed {logic rw; logic [16:0] addr; logic [7:0] wd; logic [7:0] rd;} txn_t;
   logic        clk16 = 1'b0, reset_b = 1'b0, spi_cs_b = 1'b1, spi_sclk = 1'b0, spi_mosi = 1'b0;
   logic        spi_miso, busy, err, pi_rw_b, pi_pending, pi_done;
   logic [16:0] pi_addr;
   logic [7:0]  pi_wr_data, pi_rd_data;
   logic [7:0]  tx [8];
   logic [7:0]  rx [8];
   txn_t        obs_q [$];
   int          n_chk = 0, n_fail = 0, n_pend = 0;
   logic        pend_q = 1'b0;
   logic        arb_auto = 1'b1, man_done = 1'b0, rd_fix_en = 1'b0;
   logic [7:0]  rd_fix = 8'h00;
   logic [16:0] exp_addr = '0;
   logic [7:0]  exp_rd = '0;
   logic        exp_ovr = 1'b0, exp_to = 1'b0;
   int          np0, cnt;
   txn_t        t;

   pi_bus_initiator #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)) dut (
      .clk16(clk16), .reset_b(reset_b), .spi_cs_b(spi_cs_b), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
      .spi_miso(spi_miso), .busy(busy), .err(err), .pi_rw_b(pi_rw_b), .pi_addr(pi_addr),
      .pi_wr_data(pi_wr_data), .pi_rd_data(pi_rd_data), .pi_pending(pi_pending), .pi_done(pi_done));

   always #5 clk16 = ~clk16;

   always @(posedge clk16) begin
      pend_q <= pi_pending;
      if (pi_pending && !pend_q) n_pend <= n_pend + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Arbiter: manual mode drives pi_done directly, auto mode completes each request once.
   initial begin
      txn_t a;
      pi_done = 1'b0;
      pi_rd_data = 8'h00;
      forever begin
         @(negedge clk16);
         if (!arb_auto) pi_done = man_done;
         else if (pi_pending && !pi_done) begin
            a = '{rw: pi_rw_b, addr: pi_addr, wd: pi_wr_data, rd: 8'h00};
            repeat ($urandom_range(0, 6)) @(negedge clk16);
            check("hold_addr", pi_addr, a.addr);
            pi_rd_data = rd_fix_en ? rd_fix : 8'($urandom);
            a.rd = pi_rd_data;
            pi_done = 1'b1;
            for (int i = 0; i < 50 && pi_pending; i++) @(negedge clk16);
            check("pend_drop", pi_pending, 0);
            obs_q.push_back(a);
            repeat ($urandom_range(0, 3)) @(negedge clk16);
            pi_done = 1'b0;
         end
      end
   end

   task automatic spi_xfer(input int n);
      spi_cs_b = 1'b0;
      repeat (H) @(negedge clk16);
      for (int k = 0; k < n; k++)
         for (int b = 7; b >= 0; b--) begin
            spi_mosi = tx[k][b];
            repeat (H) @(negedge clk16);
            rx[k][b] = spi_miso;
            spi_sclk = 1'b1;
            repeat (H) @(negedge clk16);
            spi_sclk = 1'b0;
         end
      repeat (H) @(negedge clk16);
      spi_cs_b = 1'b1;
      repeat (8) @(negedge clk16);
   endtask

   task automatic wait_idle();
      int i = 0;
      while ((busy || pi_pending || pi_done) && i < 3000) begin
         @(negedge clk16);
         i++;
      end
      check("idle", {busy, pi_pending}, 0);
   endtask

   task automatic wait_pend(input logic v);
      int i = 0;
      while (pi_pending !== v && i < 500) begin
         @(negedge clk16);
         i++;
      end
      check("pend_wait", pi_pending, v);
   endtask

   // Model: op selects execute byte (3 - op) and address source; a completed transaction advances the address.
   task automatic run_frame(input int n, input logic [7:0] b0, b1, b2, b3, b4);
      logic [1:0]  op;
      int          ex, p0, q0;
      logic        issue;
      logic [16:0] ea;
      logic [7:0]  ed;
      txn_t        o;
      tx[0] = b0; tx[1] = b1; tx[2] = b2; tx[3] = b3; tx[4] = b4;
      op = b0[7:6];
      ex = 3 - int'(op);
      issue = (n > ex);
      ea = op[1] ? exp_addr : {b0[0], b1, b2};
      ed = op[1] ? b1 : b3;
      p0 = n_pend;
      q0 = obs_q.size();
      spi_xfer(n);
      wait_idle();
      check("miso_b0", rx[0], exp_rd);
      if (b0[5]) begin
         exp_ovr = 1'b0;
         exp_to = 1'b0;
      end
      for (int k = 1; k < n; k++)
         if (k <= ex) check("status", rx[k], {1'b0, exp_ovr, exp_to, 5'b0});
      check("npend", n_pend - p0, issue);
      check("ntxn", obs_q.size() - q0, issue);
      if (issue) begin
         if (obs_q.size() > q0) begin
            o = obs_q[q0];
            check("rw", o.rw, op[0]);
            check("addr", o.addr, ea);
            if (!op[0]) check("wdata", o.wd, ed);
            if (op[0]) exp_rd = o.rd;
         end
         exp_addr = ea + 17'd1;
      end
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (5) @(negedge clk16);
      check("rst_miso", spi_miso, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err, 0);
      check("rst_rw", pi_rw_b, 1);
      check("rst_addr", pi_addr, 0);
      check("rst_wdata", pi_wr_data, 0);
      check("rst_pend", pi_pending, 0);
      reset_b = 1'b1;
      repeat (5) @(negedge clk16);

      run_frame(4, 8'h00, 8'hE8, 8'h0F, 8'h03, 8'h00);
      t = obs_q[obs_q.size()-1];
      check("plan_waddr", t.addr, 17'h0E80F);
      check("plan_wdata", t.wd, 8'h03);
      run_frame(2, 8'h80, 8'h5A, 8'h00, 8'h00, 8'h00);
      check("plan_inc", obs_q[obs_q.size()-1].addr, 17'h0E810);

      rd_fix_en = 1'b1;
      rd_fix = 8'hA5;
      run_frame(3, 8'h41, 8'h23, 8'h45, 8'h00, 8'h00);
      rd_fix_en = 1'b0;
      check("plan_raddr", obs_q[obs_q.size()-1].addr, 17'h12345);
      run_frame(1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      check("plan_rdback", rx[0], 8'hA5);
      run_frame(1, 8'hC0, 8'h00, 8'h00, 8'h00, 8'h00);
      check("plan_rnext", obs_q[obs_q.size()-1].addr, 17'h12346);

      run_frame(3, 8'h41, 8'hFF, 8'hFD, 8'h00, 8'h00);
      repeat (3) run_frame(1, 8'hC0, 8'h00, 8'h00, 8'h00, 8'h00);
      check("wrap0", obs_q[obs_q.size()-3].addr, 17'h1FFFE);
      check("wrap1", obs_q[obs_q.size()-2].addr, 17'h1FFFF);
      check("wrap2", obs_q[obs_q.size()-1].addr, 17'h00000);

      run_frame(2, 8'h00, 8'h12, 8'h00, 8'h00, 8'h00);

`ifndef PI_BUS_INITIATOR_TIMEOUT_EN
      arb_auto = 1'b0;
      man_done = 1'b0;
      np0 = n_pend;
      tx[0] = 8'h80; tx[1] = 8'h11;
      spi_xfer(2);
      wait_pend(1'b1);
      check("ovr_addr", pi_addr, exp_addr);
      check("ovr_wd", pi_wr_data, 8'h11);
      tx[0] = 8'h80; tx[1] = 8'h22;
      spi_xfer(2);
      tx[0] = 8'h00; tx[1] = 8'h00;
      spi_xfer(2);
      check("ovr_b0", rx[0], exp_rd);
      check("ovr_status", rx[1], 8'hC0);
      check("ovr_err", err, 1);
      check("ovr_hold_wd", pi_wr_data, 8'h11);
      man_done = 1'b1;
      wait_pend(1'b0);
      man_done = 1'b0;
      wait_idle();
      check("ovr_npend", n_pend - np0, 1);
      exp_addr = exp_addr + 17'd1;
      exp_ovr = 1'b1;
      arb_auto = 1'b1;
      run_frame(2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      run_frame(1, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00);
      check("clr_err", err, 0);
      run_frame(2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

      arb_auto = 1'b0;
      man_done = 1'b1;
      repeat (3) @(negedge clk16);
      np0 = n_pend;
      tx[0] = 8'h80; tx[1] = 8'h33;
      spi_xfer(2);
      repeat (30) @(negedge clk16);
      check("stuck_pend", pi_pending, 0);
      check("stuck_busy", busy, 1);
      man_done = 1'b0;
      wait_pend(1'b1);
      check("stuck_addr", pi_addr, exp_addr);
      man_done = 1'b1;
      wait_pend(1'b0);
      man_done = 1'b0;
      wait_idle();
      check("stuck_npend", n_pend - np0, 1);
      exp_addr = exp_addr + 17'd1;
      arb_auto = 1'b1;
`else
      arb_auto = 1'b0;
      man_done = 1'b0;
      tx[0] = 8'hC0;
      spi_xfer(1);
      wait_pend(1'b1);
      cnt = 0;
      while (pi_pending && cnt < 100) begin
         @(negedge clk16);
         cnt++;
      end
      check("to_len", cnt, 16);
      check("to_err", err, 1);
      wait_idle();
      exp_to = 1'b1;
      arb_auto = 1'b1;
      run_frame(2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      run_frame(1, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00);
      check("to_clr", err, 0);
      run_frame(1, 8'hC0, 8'h00, 8'h00, 8'h00, 8'h00);
`endif

      for (int f = 0; f < 30; f++)
         run_frame($urandom_range(1, 5), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));

      arb_auto = 1'b0;
      man_done = 1'b0;
      tx[0] = 8'hC0;
      spi_xfer(1);
      wait_pend(1'b1);
      @(negedge clk16);
      reset_b = 1'b0;
      #1;
      check("async_pend", pi_pending, 0);
      check("async_busy", busy, 0);
      check("async_addr", pi_addr, 0);
      check("async_rw", pi_rw_b, 1);
      repeat (3) @(negedge clk16);
      reset_b = 1'b1;
      exp_addr = '0;
      exp_rd = '0;
      exp_ovr = 1'b0;
      exp_to = 1'b0;
      arb_auto = 1'b1;
      repeat (3) @(negedge clk16);
      run_frame(1, 8'hC0, 8'h00, 8'h00, 8'h00, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
